// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared types and constants for the two-port RAM arbiter.
// Contents: FSM state enum, owner encodings, legal RAM_LAT range.
// No ports; imported by mem_arb_pick and mem_arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

  localparam logic PORT_A = 1'b0;
  localparam logic PORT_B = 1'b1;

  // Latency counter is 4 bits wide, so RAM_LAT must stay within 1..15.
  localparam int RAM_LAT_MIN = 1;
  localparam int RAM_LAT_MAX = 15;

endpackage

// File: rtl/mem_arb_if.sv
// mem_arb_if: one bus master's REQ/ACK access port to the shared RAM.
// Ports: req/wren/addr/wdata driven by the master; ack (1-cycle pulse) and
//   rdata (held until the port's next completed read) driven by the arbiter.
interface mem_arb_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 8
);
  logic              req;
  logic              wren;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic              ack;
  logic [DATA_W-1:0] rdata;

  modport master (output req, wren, addr, wdata, input ack, rdata);
  modport slave  (input req, wren, addr, wdata, output ack, rdata);
endinterface

// File: rtl/mem_arb_pick.sv
// mem_arb_pick: combinational winner select between ports A and B.
// Ports: a_req, b_req, ptr (priority pointer) in; grant_vld, grant (owner) out.
// Macro MEM_ARB_RR_EN: defined -> ptr breaks ties; undefined -> A always wins.
module mem_arb_pick
  import mem_arb_pkg::*;
(
  input  logic a_req,
  input  logic b_req,
  input  logic ptr,
  output logic grant_vld,
  output logic grant
);

`ifdef MEM_ARB_RR_EN
  always_comb begin
    grant_vld = a_req | b_req;
    grant     = PORT_A;
    if (a_req && b_req) begin
      grant = ptr;
    end else if (b_req) begin
      grant = PORT_B;
    end
  end
`else
  // Fixed priority ignores the pointer.
  logic unused_ptr;
  assign unused_ptr = ptr;

  always_comb begin
    grant_vld = a_req | b_req;
    grant     = a_req ? PORT_A : PORT_B;
  end
`endif

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one synchronous RAM between two REQ/ACK masters, one
//   access at a time (IDLE -> ACCESS for RAM_LAT cycles -> DONE -> IDLE).
// Ports: clk, rst_n (async, active-low); a_if/b_if master ports (slave side);
//   m_addr/m_wdata/m_wren to the RAM, m_rdata from it (valid RAM_LAT edges
//   after m_addr). Macro MEM_ARB_RR_EN selects round-robin, else A-first.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 8,
  parameter int RAM_LAT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  mem_arb_if.slave          a_if,
  mem_arb_if.slave          b_if,
  output logic [ADDR_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_wdata,
  output logic              m_wren,
  input  logic [DATA_W-1:0] m_rdata
);

  generate
    if (RAM_LAT < RAM_LAT_MIN || RAM_LAT > RAM_LAT_MAX) begin : g_bad_lat
      $error("mem_arbiter: RAM_LAT must be within 1..15");
    end
  endgenerate

  localparam logic [3:0] CNT_LAST = 4'(RAM_LAT - 1);

  state_t            state;
  logic              owner;
  logic              ptr;
  logic [3:0]        cnt;
  logic              wren_l;
  logic              a_ack;
  logic              b_ack;
  logic [DATA_W-1:0] a_rdata;
  logic [DATA_W-1:0] b_rdata;

  logic              grant_vld;
  logic              grant;
  logic              sel_wren;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;

  mem_arb_pick u_pick (
    .a_req     (a_if.req),
    .b_req     (b_if.req),
    .ptr       (ptr),
    .grant_vld (grant_vld),
    .grant     (grant)
  );

  always_comb begin
    sel_wren  = a_if.wren;
    sel_addr  = a_if.addr;
    sel_wdata = a_if.wdata;
    if (grant == PORT_B) begin
      sel_wren  = b_if.wren;
      sel_addr  = b_if.addr;
      sel_wdata = b_if.wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      owner   <= PORT_A;
      ptr     <= PORT_A;
      cnt     <= 4'd0;
      wren_l  <= 1'b0;
      m_addr  <= '0;
      m_wdata <= '0;
      m_wren  <= 1'b0;
      a_ack   <= 1'b0;
      b_ack   <= 1'b0;
      a_rdata <= '0;
      b_rdata <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          a_ack  <= 1'b0;
          b_ack  <= 1'b0;
          m_wren <= 1'b0;
          if (grant_vld) begin
            owner   <= grant;
            // Pointer favours the port that lost this grant.
            ptr     <= ~grant;
            cnt     <= 4'd0;
            m_addr  <= sel_addr;
            m_wdata <= sel_wdata;
            // Write strobe is live only during the first ACCESS cycle.
            m_wren  <= sel_wren;
            wren_l  <= sel_wren;
            state   <= ST_ACCESS;
          end
        end
        ST_ACCESS: begin
          m_wren <= 1'b0;
          cnt    <= cnt + 4'd1;
          if (cnt == CNT_LAST) begin
            if (!wren_l) begin
              if (owner == PORT_B) b_rdata <= m_rdata;
              else                 a_rdata <= m_rdata;
            end
            if (owner == PORT_B) b_ack <= 1'b1;
            else                 a_ack <= 1'b1;
            state <= ST_DONE;
          end
        end
        ST_DONE: begin
          a_ack <= 1'b0;
          b_ack <= 1'b0;
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  assign a_if.ack   = a_ack;
  assign a_if.rdata = a_rdata;
  assign b_if.ack   = b_ack;
  assign b_if.rdata = b_rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed checks of mem_arbiter with RAM_LAT=1 (dut) and
//   RAM_LAT=3 (dut3), each behind a small RAM model.
// Build with or without MEM_ARB_RR_EN; expectations follow the macro.
module tb_mem_arbiter;

`ifdef MEM_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  mem_arb_if #(.ADDR_W(16), .DATA_W(8)) a_if ();
  mem_arb_if #(.ADDR_W(16), .DATA_W(8)) b_if ();
  mem_arb_if #(.ADDR_W(16), .DATA_W(8)) a3_if ();
  mem_arb_if #(.ADDR_W(16), .DATA_W(8)) b3_if ();

  logic [15:0] m_addr, m_addr3;
  logic [7:0]  m_wdata, m_wdata3, m_rdata, m_rdata3;
  logic        m_wren, m_wren3;

  mem_arbiter #(.ADDR_W(16), .DATA_W(8), .RAM_LAT(1)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .a_if    (a_if),
    .b_if    (b_if),
    .m_addr  (m_addr),
    .m_wdata (m_wdata),
    .m_wren  (m_wren),
    .m_rdata (m_rdata)
  );

  mem_arbiter #(.ADDR_W(16), .DATA_W(8), .RAM_LAT(3)) dut3 (
    .clk     (clk),
    .rst_n   (rst_n),
    .a_if    (a3_if),
    .b_if    (b3_if),
    .m_addr  (m_addr3),
    .m_wdata (m_wdata3),
    .m_wren  (m_wren3),
    .m_rdata (m_rdata3)
  );

  // RAM models. The arbiter's m_addr is already a register, so an array
  // lookup followed by RAM_LAT-1 register stages presents the data at the
  // RAM_LAT-th edge after the address was latched.
  logic [7:0] mem1 [0:65535];
  logic [7:0] mem3 [0:65535];
  logic [7:0] pipe3 [0:1];
  bit         pre_done = 1'b0;

  always @(posedge clk) begin
    if (!pre_done) begin
      mem1[16'hFFFF] <= 8'hC3;
      mem1[16'h0100] <= 8'h11;
      mem1[16'h0200] <= 8'h22;
      mem1[16'h0055] <= 8'h00;
      mem1[16'h0010] <= 8'h00;
      mem3[16'h4000] <= 8'h3C;
      mem3[16'h4001] <= 8'hD2;
      pre_done       <= 1'b1;
    end else begin
      if (m_wren)  mem1[m_addr]  <= m_wdata;
      if (m_wren3) mem3[m_addr3] <= m_wdata3;
    end
    pipe3[0] <= mem3[m_addr3];
    pipe3[1] <= pipe3[0];
  end

  assign m_rdata  = mem1[m_addr];
  assign m_rdata3 = pipe3[1];

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Cycles until the selected ACK is seen; -1 if it never arrives.
  task automatic wait_ack(input bit sel3, input bit port_b, output int cyc);
    logic ack;
    cyc = -1;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (sel3) ack = port_b ? b3_if.ack : a3_if.ack;
      else      ack = port_b ? b_if.ack  : a_if.ack;
      if (ack) begin
        cyc = i;
        break;
      end
    end
  endtask

  // Cycles until either ACK on dut; who = 1 when B was acknowledged.
  task automatic wait_any(output int cyc, output bit who);
    cyc = -1;
    who = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (a_if.ack || b_if.ack) begin
        cyc = i;
        who = b_if.ack;
        break;
      end
    end
  endtask

  task automatic set_req(input bit port_b, input bit req, input bit wren,
                         input logic [15:0] addr, input logic [7:0] wdata);
    if (port_b) begin
      b_if.req = req; b_if.wren = wren; b_if.addr = addr; b_if.wdata = wdata;
    end else begin
      a_if.req = req; a_if.wren = wren; a_if.addr = addr; a_if.wdata = wdata;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    bit who;

    rst_n = 1'b0;
    set_req(1'b0, 1'b0, 1'b0, 16'h0, 8'h0);
    set_req(1'b1, 1'b0, 1'b0, 16'h0, 8'h0);
    a3_if.req = 1'b0; a3_if.wren = 1'b0; a3_if.addr = 16'h0; a3_if.wdata = 8'h0;
    b3_if.req = 1'b0; b3_if.wren = 1'b0; b3_if.addr = 16'h0; b3_if.wdata = 8'h0;
    tick(); tick(); tick();

    chk("rst_a_ack",   a_if.ack,   1'b0);
    chk("rst_b_ack",   b_if.ack,   1'b0);
    chk("rst_m_wren",  m_wren,     1'b0);
    chk("rst_m_addr",  m_addr,     16'h0);
    chk("rst_m_wdata", m_wdata,    8'h0);
    chk("rst_a_rdata", a_if.rdata, 8'h0);
    chk("rst_b_rdata", b_if.rdata, 8'h0);

    rst_n = 1'b1;
    tick();

    // Contention: both masters hold REQ for reads.
    set_req(1'b0, 1'b1, 1'b0, 16'h0100, 8'h0);
    set_req(1'b1, 1'b1, 1'b0, 16'h0200, 8'h0);
    for (int g = 0; g < 4; g++) begin
      wait_any(cyc, who);
      chk("t2_gap", cyc, (g == 0) ? 32'd2 : 32'd3);
      chk("t2_who", {31'd0, who}, RR ? 32'(g % 2) : 32'd0);
    end
    set_req(1'b0, 1'b0, 1'b0, 16'h0, 8'h0);
    set_req(1'b1, 1'b0, 1'b0, 16'h0, 8'h0);
    chk("t2_a_rdata", a_if.rdata, 8'h11);
    chk("t2_b_rdata", b_if.rdata, RR ? 8'h22 : 8'h00);
    tick();

    // A write 5A @1234, then back-to-back read of the same address.
    set_req(1'b0, 1'b1, 1'b1, 16'h1234, 8'h5A);
    tick();
    chk("t1_wren_c1",  m_wren,   1'b1);
    chk("t1_addr_c1",  m_addr,   16'h1234);
    chk("t1_wdata_c1", m_wdata,  8'h5A);
    chk("t1_ack_c1",   a_if.ack, 1'b0);
    tick();
    chk("t1_wren_c2",  m_wren,   1'b0);
    chk("t1_ack_c2",   a_if.ack, 1'b1);
    a_if.wren = 1'b0;
    wait_ack(1'b0, 1'b0, cyc);
    chk("t5_b2b_gap",  cyc,        32'd3);
    chk("t1_rd_data",  a_if.rdata, 8'h5A);
    chk("t1_addr_hold", m_addr,    16'h1234);
    set_req(1'b0, 1'b0, 1'b0, 16'h0, 8'h0);
    tick();

    // B reads preloaded top address while A is idle.
    set_req(1'b1, 1'b1, 1'b0, 16'hFFFF, 8'h0);
    wait_ack(1'b0, 1'b1, cyc);
    chk("t3_lat",      cyc,        32'd2);
    chk("t3_b_rdata",  b_if.rdata, 8'hC3);
    chk("t3_a_keep",   a_if.rdata, 8'h5A);
    set_req(1'b1, 1'b0, 1'b0, 16'h0, 8'h0);
    tick();

    // B writes, A reads it back.
    set_req(1'b1, 1'b1, 1'b1, 16'h0010, 8'hAA);
    wait_ack(1'b0, 1'b1, cyc);
    chk("t6_wr_lat",   cyc,        32'd2);
    chk("t6_b_keep_w", b_if.rdata, 8'hC3);
    set_req(1'b1, 1'b0, 1'b0, 16'h0, 8'h0);
    tick();
    set_req(1'b0, 1'b1, 1'b0, 16'h0010, 8'h0);
    wait_ack(1'b0, 1'b0, cyc);
    chk("t6_rd_lat",   cyc,        32'd2);
    chk("t6_a_rdata",  a_if.rdata, 8'hAA);
    chk("t6_b_keep_r", b_if.rdata, 8'hC3);
    set_req(1'b0, 1'b0, 1'b0, 16'h0, 8'h0);
    tick();

    // Reset in the ACCESS cycle of an A write.
    set_req(1'b0, 1'b1, 1'b1, 16'h0055, 8'h77);
    tick();
    chk("t4_wren_pre", m_wren, 1'b1);
    #2;
    rst_n = 1'b0;
    set_req(1'b0, 1'b0, 1'b0, 16'h0, 8'h0);
    #1;
    chk("t4_wren_async", m_wren,     1'b0);
    chk("t4_m_addr",     m_addr,     16'h0);
    chk("t4_m_wdata",    m_wdata,    8'h0);
    chk("t4_a_rdata",    a_if.rdata, 8'h0);
    chk("t4_b_rdata",    b_if.rdata, 8'h0);
    tick();
    chk("t4_no_ack",     a_if.ack,   1'b0);
    rst_n = 1'b1;
    tick();
    chk("t4_no_ack_rel", a_if.ack,   1'b0);
    // Pointer back at A: A wins contention, and the aborted write left 0x55 alone.
    set_req(1'b0, 1'b1, 1'b0, 16'h0055, 8'h0);
    set_req(1'b1, 1'b1, 1'b0, 16'h0100, 8'h0);
    wait_any(cyc, who);
    chk("t4_post_lat", cyc,              32'd2);
    chk("t4_post_who", {31'd0, who},     32'd0);
    chk("t4_no_write", a_if.rdata,       8'h00);
    set_req(1'b0, 1'b0, 1'b0, 16'h0, 8'h0);
    set_req(1'b1, 1'b0, 1'b0, 16'h0, 8'h0);
    tick();

    // RAM_LAT=3: ACK at cycle 4, back-to-back every 5 cycles.
    a3_if.req = 1'b1; a3_if.wren = 1'b0; a3_if.addr = 16'h4000;
    wait_ack(1'b1, 1'b0, cyc);
    chk("t5_lat3",       cyc,         32'd4);
    chk("t5_lat3_data",  a3_if.rdata, 8'h3C);
    a3_if.addr = 16'h4001;
    wait_ack(1'b1, 1'b0, cyc);
    chk("t5_lat3_b2b",   cyc,         32'd5);
    chk("t5_lat3_data2", a3_if.rdata, 8'hD2);
    a3_if.req = 1'b0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
